rv32i_imem_fetch: RTL
=====================

Name: rv32i_imem_fetch

Overview:
Parametrised instruction memory with a valid/ready fetch interface. It replaces the single-cycle combinational-address instruction memory. It supports configurable read latency, response backpressure through an internal response FIFO, pipeline flush, fault reporting for misaligned and out-of-range addresses, and a write port for loading programs. It sits between the IF stage PC logic and the IF/ID pipeline register.

Parameters:
INST_WIDTH, 32, instruction word width in bits
ADDR_WIDTH, 32, byte-address width
DEPTH, 1024, memory depth in words; must be a power of 2
LATENCY, 1, cycles from request accept to data entering the response FIFO; legal range 1..4
RSP_DEPTH, LATENCY+1, response FIFO entries; must be >= LATENCY+1
INIT_FILE, "", hex image loaded with $readmemh at elaboration; no load when the string is empty
NOP_INST, 32'h0000_0013, instruction returned on a fault

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  fetch request valid
o_req_ready  out  1  request can be accepted this cycle
i_req_addr  in  ADDR_WIDTH  fetch byte address
o_rsp_valid  out  1  response valid (head of the response FIFO)
i_rsp_ready  in  1  consumer accepts the response
o_rsp_inst  out  INST_WIDTH  fetched instruction
o_rsp_addr  out  ADDR_WIDTH  byte address of the request that produced this response
o_rsp_fault  out  1  1 when the address was misaligned or out of range
i_flush  in  1  discard all in-flight requests and buffered responses
i_wr_en  in  1  program-load write enable
i_wr_addr  in  ADDR_WIDTH  write byte address; bits [1:0] are ignored
i_wr_data  in  INST_WIDTH  write data

Behaviour:
- Reset (rst_n=0, asynchronous): clears the in-flight pipeline valids, FIFO pointers, count and all response registers. After reset, o_rsp_valid=0, o_rsp_inst=0, o_rsp_addr=0, o_rsp_fault=0, and o_req_ready=1 once rst_n deasserts. Memory contents are not reset.
- Request accept: a request is accepted on a rising edge where i_req_valid && o_req_ready.
- Latency: an accepted request appears at the FIFO tail exactly LATENCY cycles later. o_rsp_valid is high no earlier than LATENCY cycles after accept; with an empty FIFO it is high exactly then.
- Credit rule: o_req_ready = !i_flush && (inflight + fifo_count < RSP_DEPTH).
  - inflight counts accepted requests still in the LATENCY pipeline.
  - Because of this rule the FIFO never overflows and no response is dropped.
  - o_req_ready depends only on registered state and i_flush; it has no path from i_req_valid.
- Response pop: the head entry is popped on a rising edge where o_rsp_valid && i_rsp_ready. A push and a pop in the same cycle leave the count unchanged. Pointers wrap modulo RSP_DEPTH.
- Ordering: responses are strictly in request order.
- Fault: raised when addr[1:0] != 0 or addr[ADDR_WIDTH-1:2] >= DEPTH.
  - The response has o_rsp_fault=1 and o_rsp_inst=NOP_INST.
  - The memory is not read on a fault.
  - o_rsp_addr holds the original faulting address.
- Word index: addr[$clog2(DEPTH)+1:2].
- Flush (i_flush=1 at a rising edge): clears all pipeline valids and empties the FIFO. o_rsp_valid=0 in the next cycle. A request presented in the flush cycle is not accepted, since o_req_ready=0. A pop in the flush cycle is ignored. A flush has no effect on memory contents.
- Write: i_wr_en writes i_wr_data to word i_wr_addr[$clog2(DEPTH)+1:2] on the rising edge. Out-of-range writes are ignored.
- Read-during-write to the same word in the same cycle: the read returns the old data (read-first).
- Reset mid-operation: all in-flight requests and buffered responses are lost. No response emerges after rst_n deasserts until a new request is accepted.
- Memory is inferable as block RAM: one synchronous read port and one write port. Additional LATENCY-1 stages are output registers.

Test Plan:
- Reset, then load words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F. Issue addresses 0, 4, 8, 12 back-to-back with i_rsp_ready=1 and LATENCY=1. Required: o_rsp_valid from cycle 1 after the first accept, instructions in order, o_rsp_addr = 0, 4, 8, 12, o_rsp_fault=0.
- Backpressure with LATENCY=2, RSP_DEPTH=3 and i_rsp_ready=0. Required: exactly 3 requests are accepted, then o_req_ready=0. After i_rsp_ready=1, all 3 responses come out in order, and o_req_ready rises the cycle after the first pop.
- Request address 6, then request address 4*DEPTH. Required: both responses have o_rsp_fault=1 and o_rsp_inst=32'h00000013, with o_rsp_addr=6 and 4*DEPTH respectively.
- Fill 2 responses plus 1 in flight, then pulse i_flush. Required: o_rsp_valid=0 the next cycle, o_req_ready=0 during the flush cycle, and no stale response ever appears afterwards.
- Write 32'hDEADBEEF to word 5 while requesting address 20 in the same cycle. Required: the response carries the old word. A second read of address 20 returns 32'hDEADBEEF.
- Assert rst_n=0 asynchronously mid-burst, between clock edges. Required: outputs clear immediately without waiting for a clock. Memory word 0 still reads 32'h00500093 after reset.

Source files
------------

// File: rtl/rv32i_imem_fetch.sv
// Instruction memory with a valid/ready fetch port, configurable read latency and a
// credit-guarded response FIFO so that responses are never dropped under backpressure.
module rv32i_imem_fetch #(
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter int                    LATENCY    = 1,
    parameter int                    RSP_DEPTH  = LATENCY + 1,
    parameter                        INIT_FILE  = "",
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [INST_WIDTH-1:0] o_rsp_inst,
    output logic [ADDR_WIDTH-1:0] o_rsp_addr,
    output logic                  o_rsp_fault,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [INST_WIDTH-1:0] i_wr_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + LATENCY + 1);

    logic [INST_WIDTH-1:0] r_mem [DEPTH];
    logic [INST_WIDTH-1:0] r_rd_data;

    logic          w_accept;
    logic          w_req_fault;
    logic [AW-1:0] w_rd_idx;
    logic          w_wr_ok;
    logic [AW-1:0] w_wr_idx;
    logic          w_unused;

    assign w_accept    = i_req_valid && o_req_ready;
    assign w_req_fault = (i_req_addr[1:0] != 2'b00) || ((i_req_addr >> (AW + 2)) != '0);
    assign w_rd_idx    = i_req_addr[AW+1:2];
    assign w_wr_ok     = i_wr_en && ((i_wr_addr >> (AW + 2)) == '0);
    assign w_wr_idx    = i_wr_addr[AW+1:2];
    assign w_unused    = ^i_wr_addr[1:0];

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[w_wr_idx] <= i_wr_data;
        if (w_accept && !w_req_fault) r_rd_data <= r_mem[w_rd_idx];
    end

    logic                  r_s0_vld;
    logic [ADDR_WIDTH-1:0] r_s0_addr;
    logic                  r_s0_flt;
    logic [INST_WIDTH-1:0] w_s0_inst;

    // o_req_ready is low during a flush, so the accept itself clears this stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_vld  <= 1'b0;
            r_s0_addr <= '0;
            r_s0_flt  <= 1'b0;
        end else begin
            r_s0_vld <= w_accept;
            if (w_accept) begin
                r_s0_addr <= i_req_addr;
                r_s0_flt  <= w_req_fault;
            end
        end
    end

    assign w_s0_inst = r_s0_flt ? NOP_INST : r_rd_data;

    logic                  w_tail_vld;
    logic [INST_WIDTH-1:0] w_tail_inst;
    logic [ADDR_WIDTH-1:0] w_tail_addr;
    logic                  w_tail_flt;
    logic [CW-1:0]         w_inflight;

    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_tail_vld  = r_s0_vld;
            assign w_tail_inst = w_s0_inst;
            assign w_tail_addr = r_s0_addr;
            assign w_tail_flt  = r_s0_flt;
            assign w_inflight  = CW'(r_s0_vld);
        end else begin : g_oreg
            localparam int NO = LATENCY - 1;
            logic                  r_ov [NO];
            logic [INST_WIDTH-1:0] r_od [NO];
            logic [ADDR_WIDTH-1:0] r_oa [NO];
            logic                  r_of [NO];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NO; i++) begin
                        r_ov[i] <= 1'b0;
                        r_od[i] <= '0;
                        r_oa[i] <= '0;
                        r_of[i] <= 1'b0;
                    end
                end else begin
                    r_ov[0] <= r_s0_vld && !i_flush;
                    r_od[0] <= w_s0_inst;
                    r_oa[0] <= r_s0_addr;
                    r_of[0] <= r_s0_flt;
                    for (int i = 1; i < NO; i++) begin
                        r_ov[i] <= r_ov[i-1] && !i_flush;
                        r_od[i] <= r_od[i-1];
                        r_oa[i] <= r_oa[i-1];
                        r_of[i] <= r_of[i-1];
                    end
                end
            end

            always_comb begin
                w_inflight = CW'(r_s0_vld);
                for (int i = 0; i < NO; i++) w_inflight = w_inflight + CW'(r_ov[i]);
            end

            assign w_tail_vld  = r_ov[NO-1];
            assign w_tail_inst = r_od[NO-1];
            assign w_tail_addr = r_oa[NO-1];
            assign w_tail_flt  = r_of[NO-1];
        end
    endgenerate

    logic [INST_WIDTH-1:0] r_fi [RSP_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fa [RSP_DEPTH];
    logic                  r_ff [RSP_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_push = w_tail_vld && !i_flush;
    assign w_pop  = o_rsp_valid && i_rsp_ready && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fi[r_wr_ptr] <= w_tail_inst;
            r_fa[r_wr_ptr] <= w_tail_addr;
            r_ff[r_wr_ptr] <= w_tail_flt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is not reset; gating on valid keeps the outputs at zero when empty.
    assign o_rsp_valid = (r_count != '0);
    assign o_rsp_inst  = o_rsp_valid ? r_fi[r_rd_ptr] : '0;
    assign o_rsp_addr  = o_rsp_valid ? r_fa[r_rd_ptr] : '0;
    assign o_rsp_fault = o_rsp_valid && r_ff[r_rd_ptr];
    assign o_req_ready = !i_flush && ((w_inflight + r_count) < CW'(RSP_DEPTH));

endmodule
